lm32_tlb_assoc: RTL

LM32_TLB_ASSOC -- requirements
Module: lm32_tlb_assoc

---
 rtl/lm32_tlb_pkg.sv | 23 ++
 rtl/lm32_tlb_way.sv | 51 +++++
 rtl/lm32_tlb_assoc.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/lm32_tlb_pkg.sv
// lm32_tlb_pkg: shared FSM states, TLB entry record and address-width helpers.
// Optional feature macro CFG_TLB_ASID_EN adds an ASID field to every entry.
// Fields are held at 32 bits; unused upper bits stay zero and fold away in synthesis.
package lm32_tlb_pkg;
   typedef enum logic {IDLE, FLUSH} tlb_state_t;
   typedef struct packed {
      logic valid;
`ifdef CFG_TLB_ASID_EN
      logic [31:0] asid;
`endif
      logic [31:0] tag;
      logic [31:0] pfn;
   } tlb_entry_t;
   function automatic int off_w(int page_size);
      return $clog2(page_size);
   endfunction
   function automatic int idx_w(int sets);
      return $clog2(sets);
   endfunction
   function automatic int vic_w(int ways);
      return ways > 1 ? $clog2(ways) : 1;
   endfunction
endpackage

// File: rtl/lm32_tlb_way.sv
// lm32_tlb_way: storage for one TLB way, with one read port and one write port.
// Each port has its own tag comparator.
// Ports:
//   clk_i            - clock
//   asid             - current ASID (present only with CFG_TLB_ASID_EN)
//   rd_idx / rd_tag  - lookup set and tag
//   rd_hit / rd_pfn  - lookup match and stored PFN
//   wr_idx / wr_tag  - write set and tag
//   wr_valid         - target entry valid
//   wr_hit           - target entry matches wr_tag
//   we / wr_data     - write strobe and record
module lm32_tlb_way
   import lm32_tlb_pkg::*;
#(
   parameter int SETS = 64,
   parameter int IW = 6
)(
`ifdef CFG_TLB_ASID_EN
   input  logic [31:0]   asid,
`endif
   input  logic          clk_i,
   input  logic [IW-1:0] rd_idx,
   input  logic [31:0]   rd_tag,
   output logic          rd_hit,
   output logic [31:0]   rd_pfn,
   input  logic [IW-1:0] wr_idx,
   input  logic [31:0]   wr_tag,
   output logic          wr_valid,
   output logic          wr_hit,
   input  logic          we,
   input  tlb_entry_t    wr_data
);
   tlb_entry_t mem [SETS];
   tlb_entry_t rd_e;
   logic rd_asid_ok, wr_asid_ok;
   assign rd_e = mem[rd_idx];
`ifdef CFG_TLB_ASID_EN
   assign rd_asid_ok = rd_e.asid == asid;
   assign wr_asid_ok = mem[wr_idx].asid == asid;
`else
   assign rd_asid_ok = 1'b1;
   assign wr_asid_ok = 1'b1;
`endif
   assign rd_hit = rd_e.valid && rd_e.tag == rd_tag && rd_asid_ok;
   assign rd_pfn = rd_e.pfn;
   assign wr_valid = mem[wr_idx].valid;
   assign wr_hit = wr_valid && mem[wr_idx].tag == wr_tag && wr_asid_ok;
   // The read is combinational, so a lookup in the same cycle as a write sees the old contents.
   always_ff @(posedge clk_i)
      if (we) mem[wr_idx] <= wr_data;
endmodule

// File: rtl/lm32_tlb_assoc.sv
// lm32_tlb_assoc: set-associative TLB with registered lookups, round-robin replacement and a walking flush.
// Optional macro CFG_TLB_ASID_EN tags entries with asid_i.
// Ports:
//   clk_i, rst_i (async, active-low)
//   enable_i, asid_i
//   lookup_valid_i, lookup_vaddr_i -> lookup_hit_o, lookup_miss_o, lookup_paddr_o, miss_addr_o
//   upd_valid_i, upd_vaddr_i, upd_paddr_i
//   cmd_flush_i, cmd_inval_i, cmd_vaddr_i
//   busy_o
module lm32_tlb_assoc
   import lm32_tlb_pkg::*;
#(
   parameter int SETS = 64,
   parameter int WAYS = 2,
   parameter int PAGE_SIZE = 4096,
   parameter int ASID_W = 8
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   input  logic [ASID_W-1:0] asid_i,
   input  logic              lookup_valid_i,
   input  logic [31:0]       lookup_vaddr_i,
   output logic              lookup_hit_o,
   output logic              lookup_miss_o,
   output logic [31:0]       lookup_paddr_o,
   output logic [31:0]       miss_addr_o,
   input  logic              upd_valid_i,
   input  logic [31:0]       upd_vaddr_i,
   input  logic [31:0]       upd_paddr_i,
   input  logic              cmd_flush_i,
   input  logic              cmd_inval_i,
   input  logic [31:0]       cmd_vaddr_i,
   output logic              busy_o
);
   localparam int OW = off_w(PAGE_SIZE);
   localparam int IW = idx_w(SETS);
   localparam int VW = vic_w(WAYS);
   localparam logic [31:0] OFF_MASK = 32'(PAGE_SIZE - 1);
   tlb_state_t state;
   logic [IW-1:0] cnt, wr_idx, u_idx;
   logic [VW-1:0] victim [SETS];
   logic [VW-1:0] tgt;
   logic [WAYS-1:0] rd_hit, wr_valid, wr_hit, we;
   logic [31:0] rd_pfn [WAYS];
   logic [31:0] pfn_sel, wr_tag;
   logic any_hit, hit_any, free_any, flushing, idle_cmd, do_inval, do_upd;
   tlb_entry_t wr_data;
   assign flushing = state == FLUSH;
   assign idle_cmd = !flushing && !cmd_flush_i;
   assign do_inval = idle_cmd && cmd_inval_i;
   assign do_upd = idle_cmd && !cmd_inval_i && upd_valid_i;
   assign u_idx = upd_vaddr_i[OW +: IW];
   assign wr_idx = flushing ? cnt : cmd_inval_i ? cmd_vaddr_i[OW +: IW] : u_idx;
   assign wr_tag = (cmd_inval_i ? cmd_vaddr_i : upd_vaddr_i) >> (OW + IW);
   // Reset forces the state to FLUSH, but busy_o stays low while reset is held.
   assign busy_o = rst_i && flushing;
`ifndef CFG_TLB_ASID_EN
   logic unused_asid;
   assign unused_asid = ^asid_i;
`endif
   always_comb begin
      wr_data = '0;
      wr_data.valid = do_upd;
`ifdef CFG_TLB_ASID_EN
      wr_data.asid = 32'(asid_i);
`endif
      wr_data.tag = wr_tag;
      wr_data.pfn = upd_paddr_i >> OW;
   end
   // The descending scan lets the lowest-numbered matching way win.
   always_comb begin
      pfn_sel = '0;
      any_hit = 1'b0;
      for (int i = WAYS - 1; i >= 0; i--)
         if (rd_hit[i]) begin
            pfn_sel = rd_pfn[i];
            any_hit = 1'b1;
         end
   end
   // Update target priority: matching way, then lowest invalid way, then the set's victim.
   // The match scan runs last so that it overrides the other choices.
   always_comb begin
      tgt = victim[u_idx];
      hit_any = 1'b0;
      free_any = 1'b0;
      for (int i = WAYS - 1; i >= 0; i--)
         if (!wr_valid[i]) begin
            tgt = VW'(i);
            free_any = 1'b1;
         end
      for (int i = WAYS - 1; i >= 0; i--)
         if (wr_hit[i]) begin
            tgt = VW'(i);
            hit_any = 1'b1;
         end
   end
   for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign we[w] = flushing || (do_inval && wr_hit[w]) || (do_upd && tgt == VW'(w));
      lm32_tlb_way #(.SETS(SETS), .IW(IW)) u_way (
`ifdef CFG_TLB_ASID_EN
         .asid(32'(asid_i)),
`endif
         .clk_i(clk_i),
         .rd_idx(lookup_vaddr_i[OW +: IW]),
         .rd_tag(lookup_vaddr_i >> (OW + IW)),
         .rd_hit(rd_hit[w]),
         .rd_pfn(rd_pfn[w]),
         .wr_idx(wr_idx),
         .wr_tag(wr_tag),
         .wr_valid(wr_valid[w]),
         .wr_hit(wr_hit[w]),
         .we(we[w]),
         .wr_data(wr_data)
      );
   end
   always_ff @(posedge clk_i or negedge rst_i)
      if (!rst_i) begin
         state <= FLUSH;
         cnt <= IW'(SETS - 1);
         lookup_hit_o <= 1'b0;
         lookup_miss_o <= 1'b0;
         lookup_paddr_o <= '0;
         miss_addr_o <= '0;
         for (int i = 0; i < SETS; i++) victim[i] <= '0;
      end else begin
         lookup_hit_o <= lookup_valid_i && !flushing && (!enable_i || any_hit);
         lookup_miss_o <= lookup_valid_i && !flushing && enable_i && !any_hit;
         if (lookup_valid_i && !flushing) begin
            if (!enable_i) lookup_paddr_o <= lookup_vaddr_i;
            else if (any_hit) lookup_paddr_o <= (pfn_sel << OW) | (lookup_vaddr_i & OFF_MASK);
            else miss_addr_o <= lookup_vaddr_i;
         end
         if (cmd_flush_i) begin
            state <= FLUSH;
            cnt <= IW'(SETS - 1);
         end else if (flushing) begin
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= IDLE;
         end
         // The victim pointer only advances when the update evicts a valid entry.
         if (do_upd && !hit_any && !free_any)
            victim[u_idx] <= victim[u_idx] == VW'(WAYS - 1) ? '0 : victim[u_idx] + 1'b1;
      end
endmodule
